wave_capture: RTL and testbench

WAVE_CAPTURE -- requirements
Module: wave_capture

---
 rtl/wave_capture.sv | 69 ++++++
 tb/tb_wave_capture.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/wave_capture.sv
// wave_capture: records a prescaled 16-bit audio stream as unsigned 8-bit bytes into a dpram write port.
module wave_capture #(
    parameter int ADDR_W   = 14,
    parameter int PRESCALE = 2999
) (
    input  logic              I_CLK,
    input  logic              I_RSTn,
    input  logic              I_START,
    input  logic              I_STOP,
    input  logic [15:0]       I_SAMPLE,
    output logic              O_WR_EN,
    output logic [ADDR_W-1:0] O_WR_ADDR,
    output logic [7:0]        O_WR_DATA,
    output logic              O_BUSY,
    output logic              O_DONE,
    output logic [ADDR_W:0]   O_LEN
);
    localparam int PW = $clog2(PRESCALE + 2);
    typedef enum logic [1:0] {IDLE, CAPTURE, FINISH} state_t;
    state_t            state;
    logic [PW-1:0]     presc;
    logic [ADDR_W-1:0] addr;
    logic              tick;
    logic              full;
    assign tick = presc == PW'(PRESCALE);
    assign full = &addr;
    always_ff @(posedge I_CLK or negedge I_RSTn) begin
        if (!I_RSTn) begin
            state     <= IDLE;
            presc     <= '0;
            addr      <= '0;
            O_WR_EN   <= 1'b0;
            O_WR_ADDR <= '0;
            O_WR_DATA <= '0;
            O_BUSY    <= 1'b0;
            O_DONE    <= 1'b0;
            O_LEN     <= '0;
        end else begin
            O_WR_EN <= 1'b0;
            O_DONE  <= 1'b0;
            case (state)
                IDLE: if (I_START) begin
                    state  <= CAPTURE;
                    presc  <= '0;
                    addr   <= '0;
                    O_LEN  <= '0;
                    O_BUSY <= 1'b1;
                end
                CAPTURE: begin
                    presc <= tick ? '0 : presc + PW'(1);
                    if (tick) begin
                        O_WR_EN   <= 1'b1;
                        O_WR_ADDR <= addr;
                        O_WR_DATA <= {~I_SAMPLE[15], I_SAMPLE[14:8]};
                        O_LEN     <= O_LEN + (ADDR_W+1)'(1);
                        if (!full) addr <= addr + ADDR_W'(1);
                    end
                    // a tick on the stop edge still writes; a full buffer ends without wrapping
                    if (I_STOP || (tick && full)) begin
                        state  <= FINISH;
                        O_BUSY <= 1'b0;
                        O_DONE <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wave_capture.sv
// tb_wave_capture: directed checks of wave_capture with PRESCALE=3, ADDR_W=3.
module tb_wave_capture;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] sample = 16'h0000;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        busy;
    logic        done;
    logic [3:0]  len;
    int          errors = 0;
    int          checks = 0;
    int          cnt;

    wave_capture #(.ADDR_W(3), .PRESCALE(3)) dut (
        .I_CLK(clk), .I_RSTn(rst_n), .I_START(start), .I_STOP(stop), .I_SAMPLE(sample),
        .O_WR_EN(wr_en), .O_WR_ADDR(wr_addr), .O_WR_DATA(wr_data),
        .O_BUSY(busy), .O_DONE(done), .O_LEN(len)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_write(input string tag, input logic [2:0] a, input logic [7:0] d);
        check({tag, "_en"}, wr_en, 1);
        check({tag, "_addr"}, wr_addr, a);
        check({tag, "_data"}, wr_data, d);
    endtask

    initial begin
        #1;
        check("rst_en", wr_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_len", len, 0);
        step(2);
        rst_n = 1'b1;
        step(3);
        check("idle_busy", busy, 0);
        check("idle_en", wr_en, 0);

        // capture 1: run to full buffer, with a stray start mid-capture
        start = 1'b1;
        sample = 16'h8000;
        step(1);
        start = 1'b0;
        check("c1_busy", busy, 1);
        check("c1_len0", len, 0);
        step(2);
        check("c1_noearly", wr_en, 0);
        step(1);
        check("c1_e3", wr_en, 0);
        step(1);
        check_write("c1_w0", 3'd0, 8'h00);
        check("c1_len1", len, 1);
        sample = 16'h7FFF;
        start = 1'b1;
        step(1);
        start = 1'b0;
        check("c1_gap", wr_en, 0);
        step(3);
        check_write("c1_w1", 3'd1, 8'hFF);
        sample = 16'h0000;
        step(4);
        check_write("c1_w2", 3'd2, 8'h80);
        sample = 16'hFFFF;
        step(4);
        check_write("c1_w3", 3'd3, 8'h7F);
        check("c1_len4", len, 4);
        for (int i = 4; i < 8; i++) begin
            step(4);
            check_write($sformatf("c1_w%0d", i), 3'(i), 8'h7F);
        end
        check("c1_done", done, 1);
        check("c1_busy_fall", busy, 0);
        check("c1_len8", len, 8);
        step(1);
        check("c1_done_pulse", done, 0);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cnt += int'(wr_en) + int'(done);
            step(1);
        end
        check("c1_quiet", cnt, 0);
        check("c1_len_hold", len, 8);

        // capture 2: stop on the third tick edge
        sample = 16'h1200;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(11);
        check("c2_w1_len", len, 2);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        check_write("c2_w2", 3'd2, 8'h92);
        check("c2_done", done, 1);
        check("c2_busy", busy, 0);
        check("c2_len", len, 3);
        step(1);
        check("c2_done_off", done, 0);
        check("c2_en_off", wr_en, 0);

        // capture 3: start and stop together in idle, then stop between ticks
        start = 1'b1;
        stop = 1'b1;
        step(1);
        start = 1'b0;
        stop = 1'b0;
        check("c3_busy", busy, 1);
        step(9);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        check("c3_done", done, 1);
        check("c3_en", wr_en, 0);
        check("c3_len", len, 2);
        step(5);
        check("c3_len_hold", len, 2);
        check("c3_idle", busy, 0);

        // capture 4: reset between writes 2 and 3
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(9);
        check("c4_len2", len, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("c4_rst_busy", busy, 0);
        check("c4_rst_len", len, 0);
        check("c4_rst_en", wr_en, 0);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            cnt += int'(done) + int'(wr_en);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(1);
            cnt += int'(done) + int'(wr_en) + int'(busy);
        end
        check("c4_no_activity", cnt, 0);
        sample = 16'h8000;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(4);
        check_write("c4_w0", 3'd0, 8'h00);
        check("c4_len1", len, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
